axi4l_reg_slave: RTL and testbench

AXI4-Lite responder (slave) register bank that terminates the S00_AXI port driven by the AXI4-Lite master BFM. It holds NUM_REGS 32-bit read/write control registers, exposes them as a flat output bus to the user logic, and emits a one-cycle pulse per register on each committed write. The write and read channels are handled by independent state machines, each with at most one transaction outstanding.

---
 rtl/axi4l_pkg.sv | 21 ++
 rtl/axi4l_strb_reg.sv | 22 ++
 rtl/axi4l_reg_slave.sv | 179 +++++++++++++++++
 tb/tb_axi4l_reg_slave.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_pkg.sv
// Shared types and constants for the AXI4-Lite register slave.
// Response codes, FSM state encodings and address decode offset.
package axi4l_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         ADDR_LSB    = 2;

    typedef enum logic [1:0] {
        W_IDLE,
        W_GOT_AW,
        W_GOT_W,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

endpackage

// File: rtl/axi4l_strb_reg.sv
// One 32-bit control register with per-byte write enables.
// Synchronous active-low reset clears it to zero.
module axi4l_strb_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [3:0]  strb,
    input  logic [31:0] wdata,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) q[8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/axi4l_reg_slave.sv
// AXI4-Lite register bank with independent write and read FSMs.
// Exposes all registers flat and pulses per register on each write.
module axi4l_reg_slave
    import axi4l_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [32*NUM_REGS-1:0]          reg_out,
    output logic [NUM_REGS-1:0]             reg_wr_pulse
);

    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = C_S_AXI_DATA_WIDTH / 8;

    wstate_t          w_state, w_next;
    rstate_t          r_state, r_next;
    logic             aw_hs, w_hs, ar_hs;
    logic             commit, wr_ok, rd_ok;
    logic [IDX_W-1:0] aw_idx_q, wr_idx, ar_idx;
    logic [DW-1:0]    w_data_q, wr_data, rd_word;
    logic [SW-1:0]    w_strb_q, wr_strb;
    logic [1:0]       bresp_q, rresp_q;
    logic [DW-1:0]    rdata_q;
    logic [NUM_REGS-1:0] reg_we, pulse_q;
    logic [DW-1:0]    regs_q [NUM_REGS];
    logic             unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0],
                         S_AXI_ARADDR[ADDR_LSB-1:0]};

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // Write FSM: readies depend on state only
    always_comb begin
        w_next        = w_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                S_AXI_AWREADY = 1'b1;
                S_AXI_WREADY  = 1'b1;
                if (S_AXI_AWVALID && S_AXI_WVALID) w_next = W_RESP;
                else if (S_AXI_AWVALID)            w_next = W_GOT_AW;
                else if (S_AXI_WVALID)             w_next = W_GOT_W;
            end
            W_GOT_AW: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID) w_next = W_RESP;
            end
            W_GOT_W: begin
                S_AXI_AWREADY = 1'b1;
                if (S_AXI_AWVALID) w_next = W_RESP;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Pick live bus values or the half that was latched earlier
    assign wr_idx  = (w_state == W_GOT_AW) ? aw_idx_q
                   : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign wr_data = (w_state == W_GOT_W) ? w_data_q : S_AXI_WDATA;
    assign wr_strb = (w_state == W_GOT_W) ? w_strb_q : S_AXI_WSTRB;
    assign commit  = (w_next == W_RESP) && (w_state != W_RESP);
    assign wr_ok   = int'(wr_idx) < NUM_REGS;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state  <= W_IDLE;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bresp_q  <= RESP_OKAY;
            pulse_q  <= '0;
        end else begin
            w_state <= w_next;
            pulse_q <= reg_we;
            if (aw_hs) aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (commit) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign reg_we[i] = commit && (wr_idx == IDX_W'(i));
        axi4l_strb_reg u_reg (
            .clk   (ACLK),
            .rst_n (ARESETN),
            .we    (reg_we[i]),
            .strb  (wr_strb),
            .wdata (wr_data),
            .q     (regs_q[i])
        );
        assign reg_out[32*i +: 32] = regs_q[i];
    end

    assign S_AXI_BRESP  = bresp_q;
    assign reg_wr_pulse = pulse_q;

    // Read FSM
    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign rd_ok  = int'(ar_idx) < NUM_REGS;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) rd_word = regs_q[i];
        end
    end

    always_comb begin
        r_next        = r_state;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                S_AXI_ARREADY = 1'b1;
                if (S_AXI_ARVALID) r_next = R_DATA;
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                rdata_q <= rd_word;
                rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign S_AXI_RDATA = rdata_q;
    assign S_AXI_RRESP = rresp_q;

endmodule

// File: tb/tb_axi4l_reg_slave.sv
// Self-checking bench for axi4l_reg_slave.
// Reference model is a plain array of registers updated per byte strobe.
`timescale 1ns/1ps
module tb_axi4l_reg_slave;

    localparam int NR = 4;

    logic          tb_ACLK = 1'b0;
    logic          aresetn;
    logic [5:0]    awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          bvalid, bready, arvalid, arready, rvalid, rready;
    logic [32*NR-1:0] reg_out;
    logic [NR-1:0] reg_wr_pulse;

    int checks   = 0;
    int failures = 0;
    logic [31:0] model [NR];

    always #5 tb_ACLK = ~tb_ACLK;

    axi4l_reg_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (6),
        .NUM_REGS           (NR)
    ) dut (
        .ACLK          (tb_ACLK),
        .ARESETN       (aresetn),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_out       (reg_out),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
    endfunction

    function automatic void model_write(logic [5:0] a, logic [31:0] d, logic [3:0] s);
        int idx = int'(a) / 4;
        if (idx < NR)
            for (int b = 0; b < 4; b++)
                if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic logic [1:0] exp_resp(logic [5:0] a);
        return (int'(a) / 4 < NR) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [NR-1:0] exp_pulse(logic [5:0] a);
        int idx = int'(a) / 4;
        return (idx < NR) ? NR'(1 << idx) : '0;
    endfunction

    function automatic logic [31:0] exp_read(logic [5:0] a);
        int idx = int'(a) / 4;
        return (idx < NR) ? model[idx] : 32'h0;
    endfunction

    function automatic logic [32*NR-1:0] exp_regs();
        logic [32*NR-1:0] v;
        for (int i = 0; i < NR; i++) v[32*i +: 32] = model[i];
        return v;
    endfunction

    task automatic do_write(
        input  logic [5:0]  a,
        input  logic [31:0] d,
        input  logic [3:0]  s,
        input  int          aw_dly,
        input  int          w_dly,
        input  int          b_dly,
        output logic [1:0]  resp,
        output logic [NR-1:0] p_now,
        output logic [NR-1:0] p_next,
        output logic        stable,
        output logic        lat_ok
    );
        bready = 1'b0;
        fork
            begin
                bit done;
                done = 0;
                repeat (aw_dly) @(negedge tb_ACLK);
                awaddr = a; awvalid = 1'b1;
                for (int i = 0; i < 40 && !done; i++) begin
                    if (awready) done = 1;
                    @(negedge tb_ACLK);
                end
                awvalid = 1'b0;
                if (!done) begin
                    checks++; failures++;
                    $display("FAIL aw_timeout addr=%h", a);
                end
            end
            begin
                bit done;
                done = 0;
                repeat (w_dly) @(negedge tb_ACLK);
                wdata = d; wstrb = s; wvalid = 1'b1;
                for (int i = 0; i < 40 && !done; i++) begin
                    if (wready) done = 1;
                    @(negedge tb_ACLK);
                end
                wvalid = 1'b0;
                if (!done) begin
                    checks++; failures++;
                    $display("FAIL w_timeout addr=%h", a);
                end
            end
        join
        lat_ok = (bvalid === 1'b1);
        p_now  = reg_wr_pulse;
        for (int i = 0; i < 20 && bvalid !== 1'b1; i++) @(negedge tb_ACLK);
        if (bvalid !== 1'b1) begin
            checks++; failures++;
            $display("FAIL b_timeout addr=%h", a);
        end
        resp   = bresp;
        stable = 1'b1;
        @(negedge tb_ACLK);
        p_next = reg_wr_pulse;
        if (bvalid !== 1'b1 || bresp !== resp || awready !== 1'b0 || wready !== 1'b0)
            stable = 1'b0;
        repeat (b_dly) begin
            @(negedge tb_ACLK);
            if (bvalid !== 1'b1 || bresp !== resp || awready !== 1'b0 || wready !== 1'b0)
                stable = 1'b0;
        end
        bready = 1'b1;
        @(negedge tb_ACLK);
        bready = 1'b0;
        if (bvalid !== 1'b0) stable = 1'b0;
    endtask

    task automatic do_read(
        input  logic [5:0]  a,
        input  int          ar_dly,
        input  int          r_dly,
        output logic [31:0] data,
        output logic [1:0]  resp,
        output logic        stable,
        output logic        lat_ok
    );
        bit done;
        done = 0;
        rready = 1'b0;
        repeat (ar_dly) @(negedge tb_ACLK);
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (arready) done = 1;
            @(negedge tb_ACLK);
        end
        arvalid = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL ar_timeout addr=%h", a);
        end
        lat_ok = (rvalid === 1'b1);
        data   = rdata;
        resp   = rresp;
        stable = 1'b1;
        repeat (r_dly) begin
            @(negedge tb_ACLK);
            if (rvalid !== 1'b1 || rdata !== data || rresp !== resp || arready !== 1'b0)
                stable = 1'b0;
        end
        rready = 1'b1;
        @(negedge tb_ACLK);
        rready = 1'b0;
        if (rvalid !== 1'b0) stable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        logic        st, lat;
        logic [5:0]  addrs [4];
        addrs = '{6'h0, 6'h4, 6'h8, 6'hC};
        aresetn = 1'b0;
        repeat (3) @(negedge tb_ACLK);
        aresetn = 1'b1;
        model_reset();
        @(negedge tb_ACLK);
        checks++;
        if ({bvalid, rvalid, reg_wr_pulse} !== '0) begin
            failures++;
            $display("FAIL reset_valids got=%b exp=0", {bvalid, rvalid, reg_wr_pulse});
        end
        checks++;
        if ({bresp, rresp, rdata} !== '0) begin
            failures++;
            $display("FAIL reset_resp got=%h exp=0", {bresp, rresp, rdata});
        end
        checks++;
        if (reg_out !== exp_regs()) begin
            failures++;
            $display("FAIL reset_regs got=%h exp=%h", reg_out, exp_regs());
        end
        foreach (addrs[k]) begin
            do_read(addrs[k], 0, 0, d, r, st, lat);
            checks++;
            if (d !== 32'h0 || r !== 2'b00) begin
                failures++;
                $display("FAIL reset_read a=%h got=%h/%b exp=0/00", addrs[k], d, r);
            end
        end
    endtask

    task automatic test_write_readback();
        logic [5:0]  addrs [4];
        logic [31:0] vals [4];
        logic [1:0]  r;
        logic [NR-1:0] pn, px;
        logic [31:0] d;
        logic        st, lat;
        addrs = '{6'h0, 6'h4, 6'h8, 6'hC};
        vals  = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
        foreach (addrs[k]) begin
            do_write(addrs[k], vals[k], 4'hF, 0, 0, 0, r, pn, px, st, lat);
            model_write(addrs[k], vals[k], 4'hF);
            checks++;
            if (r !== 2'b00 || !lat || !st) begin
                failures++;
                $display("FAIL wr_resp a=%h resp=%b lat=%b st=%b exp=00/1/1", addrs[k], r, lat, st);
            end
            checks++;
            if (pn !== exp_pulse(addrs[k]) || px !== '0) begin
                failures++;
                $display("FAIL wr_pulse a=%h got=%b,%b exp=%b,0", addrs[k], pn, px, exp_pulse(addrs[k]));
            end
            do_read(addrs[k], 0, 1, d, r, st, lat);
            checks++;
            if (d !== vals[k] || r !== 2'b00 || !lat || !st) begin
                failures++;
                $display("FAIL readback a=%h got=%h exp=%h", addrs[k], d, vals[k]);
            end
        end
        checks++;
        if (reg_out !== exp_regs()) begin
            failures++;
            $display("FAIL reg_out got=%h exp=%h", reg_out, exp_regs());
        end
    endtask

    task automatic test_split_aw_w();
        logic [1:0]  r;
        logic [NR-1:0] pn, px;
        logic [31:0] d;
        logic        st, lat;
        do_write(6'h4, 32'h5A5A1234, 4'hF, 0, 3, 4, r, pn, px, st, lat);
        model_write(6'h4, 32'h5A5A1234, 4'hF);
        checks++;
        if (r !== 2'b00 || !st || !lat || pn !== 4'b0010) begin
            failures++;
            $display("FAIL aw_first resp=%b st=%b lat=%b pulse=%b exp=00/1/1/0010", r, st, lat, pn);
        end
        do_write(6'h8, 32'h0F0F9876, 4'hF, 3, 0, 4, r, pn, px, st, lat);
        model_write(6'h8, 32'h0F0F9876, 4'hF);
        checks++;
        if (r !== 2'b00 || !st || !lat || pn !== 4'b0100) begin
            failures++;
            $display("FAIL w_first resp=%b st=%b lat=%b pulse=%b exp=00/1/1/0100", r, st, lat, pn);
        end
        do_read(6'h4, 0, 0, d, r, st, lat);
        checks++;
        if (d !== model[1]) begin
            failures++;
            $display("FAIL split_rd1 got=%h exp=%h", d, model[1]);
        end
        do_read(6'h8, 0, 0, d, r, st, lat);
        checks++;
        if (d !== model[2]) begin
            failures++;
            $display("FAIL split_rd2 got=%h exp=%h", d, model[2]);
        end
    endtask

    task automatic test_partial_strb();
        logic [1:0]  r;
        logic [NR-1:0] pn, px;
        logic [31:0] d;
        logic        st, lat;
        do_write(6'h4, 32'hABCD0001, 4'hF, 0, 0, 0, r, pn, px, st, lat);
        model_write(6'h4, 32'hABCD0001, 4'hF);
        do_write(6'h4, 32'h11223344, 4'h6, 0, 0, 0, r, pn, px, st, lat);
        model_write(6'h4, 32'h11223344, 4'h6);
        do_read(6'h4, 0, 0, d, r, st, lat);
        checks++;
        if (d !== 32'hAB223301) begin
            failures++;
            $display("FAIL partial_strb got=%h exp=AB223301", d);
        end
        do_write(6'h4, 32'hFFFFFFFF, 4'h0, 0, 0, 0, r, pn, px, st, lat);
        checks++;
        if (pn !== 4'b0010 || reg_out !== exp_regs()) begin
            failures++;
            $display("FAIL zero_strb pulse=%b regs=%h exp=0010/%h", pn, reg_out, exp_regs());
        end
    endtask

    task automatic test_slverr();
        logic [1:0]  r;
        logic [NR-1:0] pn, px;
        logic [31:0] d;
        logic        st, lat;
        do_write(6'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 1, r, pn, px, st, lat);
        checks++;
        if (r !== 2'b10 || pn !== '0 || px !== '0) begin
            failures++;
            $display("FAIL slverr_wr resp=%b pulse=%b,%b exp=10/0/0", r, pn, px);
        end
        checks++;
        if (reg_out !== exp_regs()) begin
            failures++;
            $display("FAIL slverr_regs got=%h exp=%h", reg_out, exp_regs());
        end
        do_read(6'h10, 0, 2, d, r, st, lat);
        checks++;
        if (r !== 2'b10 || d !== 32'h0 || !st) begin
            failures++;
            $display("FAIL slverr_rd got=%h/%b exp=0/10", d, r);
        end
    endtask

    task automatic test_same_cycle();
        logic [1:0]  wr, rr, r;
        logic [NR-1:0] pn, px;
        logic [31:0] d, d2;
        logic        st, lat, st2, lat2;
        do_write(6'h8, 32'hDEAD0011, 4'hF, 0, 0, 0, wr, pn, px, st, lat);
        model_write(6'h8, 32'hDEAD0011, 4'hF);
        fork
            do_write(6'h8, 32'h12345678, 4'hF, 0, 0, 0, wr, pn, px, st, lat);
            do_read(6'h8, 0, 0, d, rr, st2, lat2);
        join
        checks++;
        if (d !== 32'hDEAD0011) begin
            failures++;
            $display("FAIL same_cycle_rd got=%h exp=DEAD0011", d);
        end
        model_write(6'h8, 32'h12345678, 4'hF);
        do_read(6'h8, 0, 0, d2, r, st, lat);
        checks++;
        if (d2 !== 32'h12345678) begin
            failures++;
            $display("FAIL after_same_cycle got=%h exp=12345678", d2);
        end
    endtask

    task automatic test_random();
        logic [5:0]  a;
        logic [31:0] v, d;
        logic [3:0]  s;
        logic [1:0]  r;
        logic [NR-1:0] pn, px;
        logic        st, lat;
        for (int n = 0; n < 24; n++) begin
            a = 6'($urandom_range(0, 31));
            v = $urandom;
            s = 4'($urandom_range(0, 15));
            do_write(a, v, s, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 2), r, pn, px, st, lat);
            model_write(a, v, s);
            checks++;
            if (r !== exp_resp(a) || pn !== exp_pulse(a) || px !== '0 || !st || !lat) begin
                failures++;
                $display("FAIL rnd_wr a=%h resp=%b pulse=%b st=%b exp=%b/%b", a, r, pn, st, exp_resp(a), exp_pulse(a));
            end
            checks++;
            if (reg_out !== exp_regs()) begin
                failures++;
                $display("FAIL rnd_regs got=%h exp=%h", reg_out, exp_regs());
            end
            a = 6'($urandom_range(0, 31));
            do_read(a, $urandom_range(0, 2), $urandom_range(0, 2), d, r, st, lat);
            checks++;
            if (d !== exp_read(a) || r !== exp_resp(a) || !st || !lat) begin
                failures++;
                $display("FAIL rnd_rd a=%h got=%h/%b exp=%h/%b", a, d, r, exp_read(a), exp_resp(a));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0]  r;
        logic [NR-1:0] pn, px;
        logic [31:0] d;
        logic        st, lat;
        bit          ok;
        awaddr = 6'h4; awvalid = 1'b1;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (awready) ok = 1;
            @(negedge tb_ACLK);
        end
        awvalid = 1'b0;
        aresetn = 1'b0;
        @(negedge tb_ACLK);
        aresetn = 1'b1;
        model_reset();
        ok = 1;
        repeat (4) begin
            @(negedge tb_ACLK);
            if (bvalid !== 1'b0) ok = 0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL mid_reset_bvalid got=1 exp=0");
        end
        for (int i = 0; i < NR; i++) begin
            do_read(6'(4 * i), 0, 0, d, r, st, lat);
            checks++;
            if (d !== 32'h0) begin
                failures++;
                $display("FAIL mid_reset_rd i=%0d got=%h exp=0", i, d);
            end
        end
        do_write(6'hC, 32'hC0FFEE00, 4'hF, 3, 0, 0, r, pn, px, st, lat);
        model_write(6'hC, 32'hC0FFEE00, 4'hF);
        checks++;
        if (reg_out !== exp_regs() || pn !== 4'b1000) begin
            failures++;
            $display("FAIL post_reset_wr got=%h pulse=%b exp=%h/1000", reg_out, pn, exp_regs());
        end
    endtask

    initial begin
        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        @(negedge tb_ACLK);
        test_reset();
        test_write_readback();
        test_split_aw_w();
        test_partial_strb();
        test_slverr();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
